// File: rtl/enigma_out_buffer.sv
// Frame buffer between the enigma core and the output wrapper: captures a
// frame of N letter symbols, then streams them out with a valid/ready handshake.
module enigma_out_buffer #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned SYMB_W = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [5:0]        symb_numb_i,
  input  logic [SYMB_W-1:0] out_en_i,
  input  logic              wrap_rdy_i,
  output logic [SYMB_W-1:0] wrap_o,
  output logic              wrap_vld_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [SYMB_W-1:0] LAST_LETTER = SYMB_W'(26);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t            state_q;
  state_t            state_nxt;
  logic [PW-1:0]     wptr_q;
  logic [PW-1:0]     wptr_nxt;
  logic [PW-1:0]     rptr_q;
  logic [PW-1:0]     rptr_nxt;
  logic [PW-1:0]     n_q;
  logic [PW-1:0]     n_nxt;
  logic              err_nxt;
  logic [SYMB_W-1:0] wrap_nxt;
  logic              vld_nxt;
  logic              busy_nxt;
  logic              done_nxt;

  logic              we_c;
  logic [AW-1:0]     waddr_c;
  logic              legal_c;
  logic              illegal_c;
  logic              numb_zero_c;
  logic              numb_over_c;
  logic [PW-1:0]     n_start_c;
  logic [SYMB_W-1:0] rd_c;

  logic [SYMB_W-1:0] mem [DEPTH];

  // Symbol classification and frame-length clamp
  always_comb begin
    legal_c     = (out_en_i != '0) && (out_en_i <= LAST_LETTER);
    illegal_c   = (out_en_i > LAST_LETTER);
    numb_zero_c = (symb_numb_i == 6'd0);
    numb_over_c = (32'(symb_numb_i) > DEPTH);
    n_start_c   = numb_over_c ? PW'(DEPTH) : PW'(symb_numb_i);
  end

  // Next-state, pointer, error and registered-output computation
  always_comb begin
    state_nxt = state_q;
    wptr_nxt  = wptr_q;
    rptr_nxt  = rptr_q;
    n_nxt     = n_q;
    err_nxt   = err_o;
    we_c      = 1'b0;
    waddr_c   = wptr_q[AW-1:0];
    rd_c      = '0;
    wrap_nxt  = '0;
    vld_nxt   = 1'b0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;

    // illegal codes are dropped in every state and only flag the frame
    if (illegal_c) begin
      err_nxt = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (legal_c) begin
          if (numb_zero_c) begin
            err_nxt = 1'b1;
          end else begin
            we_c      = 1'b1;
            waddr_c   = '0;
            wptr_nxt  = PW'(1);
            n_nxt     = n_start_c;
            // a new frame clears the flag unless its own length is bad
            err_nxt   = numb_over_c;
            state_nxt = (n_start_c == PW'(1)) ? ST_DRAIN : ST_CAPTURE;
          end
        end
      end

      ST_CAPTURE: begin
        if (legal_c) begin
          we_c     = 1'b1;
          waddr_c  = wptr_q[AW-1:0];
          wptr_nxt = wptr_q + PW'(1);
          if ((wptr_q + PW'(1)) == n_q) begin
            state_nxt = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        if (legal_c) begin
          err_nxt = 1'b1;
        end
        if (wrap_rdy_i) begin
          rptr_nxt = rptr_q + PW'(1);
          if (rptr_q == (n_q - PW'(1))) begin
            state_nxt = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        if (legal_c) begin
          err_nxt = 1'b1;
        end
        wptr_nxt  = '0;
        rptr_nxt  = '0;
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // read port with write-through so a one-symbol frame drains immediately
    if (we_c && (waddr_c == rptr_nxt[AW-1:0])) begin
      rd_c = out_en_i;
    end else begin
      rd_c = mem[rptr_nxt[AW-1:0]];
    end

    vld_nxt  = (state_nxt == ST_DRAIN);
    busy_nxt = (state_nxt != ST_IDLE);
    done_nxt = (state_nxt == ST_DONE);
    wrap_nxt = vld_nxt ? rd_c : '0;
  end

  // State, pointers, frame length and outputs
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      n_q        <= '0;
      err_o      <= 1'b0;
      wrap_o     <= '0;
      wrap_vld_o <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      wptr_q     <= wptr_nxt;
      rptr_q     <= rptr_nxt;
      n_q        <= n_nxt;
      err_o      <= err_nxt;
      wrap_o     <= wrap_nxt;
      wrap_vld_o <= vld_nxt;
      busy_o     <= busy_nxt;
      done_o     <= done_nxt;
    end
  end

  // Symbol storage; contents deliberately left unreset
  always_ff @(posedge clk_i) begin
    if (we_c) begin
      mem[waddr_c] <= out_en_i;
    end
  end

endmodule

// File: tb/tb_enigma_out_buffer.sv
// Self-checking bench for enigma_out_buffer: frame vector table plus
// hand-written latency, stall, overrun, length and reset sequences.
module tb_enigma_out_buffer;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned SYMB_W = 6;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [5:0]        symb_numb_i;
  logic [SYMB_W-1:0] out_en_i;
  logic              wrap_rdy_i;
  logic [SYMB_W-1:0] wrap_o;
  logic              wrap_vld_o;
  logic              busy_o;
  logic              done_o;
  logic              err_o;

  enigma_out_buffer #(.DEPTH(DEPTH), .SYMB_W(SYMB_W)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .symb_numb_i (symb_numb_i),
    .out_en_i    (out_en_i),
    .wrap_rdy_i  (wrap_rdy_i),
    .wrap_o      (wrap_o),
    .wrap_vld_o  (wrap_vld_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int numb;
    int first;
    int len;
    int exp_xfers;
    int exp_err;
  } vec_t;

  int                checks = 0;
  int                errors = 0;
  int                xfers  = 0;
  logic [SYMB_W-1:0] exp_q [$];
  int unsigned       pool  [$];
  int unsigned       sq    [$];
  vec_t              vecs  [6];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // score any transfer happening on the coming edge, then advance one cycle
  task automatic tick();
    logic [SYMB_W-1:0] e;
    if (wrap_vld_o && wrap_rdy_i) begin
      xfers++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL xfer_unexpected actual=%0d expected=none", wrap_o);
      end else begin
        e = exp_q.pop_front();
        check("xfer_symbol", int'(wrap_o), int'(e));
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  // drive one symbol per cycle; scoreboard gets the first N legal symbols
  task automatic drive_frame(input int numb, input int unsigned syms[$]);
    int n;
    int cnt;
    n   = (numb > int'(DEPTH)) ? int'(DEPTH) : numb;
    cnt = 0;
    symb_numb_i = 6'(numb);
    foreach (syms[i]) begin
      out_en_i = SYMB_W'(syms[i]);
      if (syms[i] >= 1 && syms[i] <= 26 && cnt < n) begin
        exp_q.push_back(SYMB_W'(syms[i]));
        cnt++;
      end
      tick();
    end
    out_en_i = '0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done_o) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  initial begin
    bit seen;
    logic [SYMB_W-1:0] prev;
    int pat [7];
    int base;

    rst_i       = 1'b0;
    symb_numb_i = '0;
    out_en_i    = '0;
    wrap_rdy_i  = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_wrap", int'(wrap_o), 0);
    check("rst_vld", int'(wrap_vld_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_done", int'(done_o), 0);
    check("rst_err", int'(err_o), 0);
    rst_i = 1'b1;
    tick();

    // exact latency of a back-to-back five-symbol frame
    xfers = 0;
    sq = {8, 5, 12, 12, 15};
    drive_frame(5, sq);
    check("lat_vld_rise", int'(wrap_vld_o), 1);
    check("lat_first", int'(wrap_o), 8);
    repeat (4) tick();
    check("lat_no_early_done", int'(done_o), 0);
    tick();
    check("lat_done", int'(done_o), 1);
    check("lat_xfers", xfers, 5);
    check("lat_err", int'(err_o), 0);
    tick();
    check("lat_idle", int'(busy_o), 0);

    // vector table
    pool = {1, 0, 0, 26, 0, 13};
    vecs[0] = '{numb: 3, first: 0, len: 6, exp_xfers: 3, exp_err: 0};
    pool.push_back(20);
    vecs[1] = '{numb: 1, first: 6, len: 1, exp_xfers: 1, exp_err: 0};
    base = pool.size();
    for (int i = 0; i < 16; i++) pool.push_back($urandom_range(1, 26));
    vecs[2] = '{numb: 16, first: base, len: 16, exp_xfers: 16, exp_err: 0};
    base = pool.size();
    for (int i = 0; i < 16; i++) pool.push_back($urandom_range(1, 26));
    vecs[3] = '{numb: 40, first: base, len: 16, exp_xfers: 16, exp_err: 1};
    base = pool.size();
    pool.push_back(2); pool.push_back(30); pool.push_back(3);
    pool.push_back(4); pool.push_back(5);
    vecs[4] = '{numb: 4, first: base, len: 5, exp_xfers: 4, exp_err: 1};
    base = pool.size();
    pool.push_back(63); pool.push_back(9); pool.push_back(0); pool.push_back(10);
    vecs[5] = '{numb: 2, first: base, len: 4, exp_xfers: 2, exp_err: 0};

    wrap_rdy_i = 1'b1;
    for (int v = 0; v < 6; v++) begin
      xfers = 0;
      sq.delete();
      for (int k = 0; k < vecs[v].len; k++) sq.push_back(pool[vecs[v].first + k]);
      drive_frame(vecs[v].numb, sq);
      wait_done(64, seen);
      check($sformatf("v%0d_done", v), int'(seen), 1);
      check($sformatf("v%0d_xfers", v), xfers, vecs[v].exp_xfers);
      check($sformatf("v%0d_err", v), int'(err_o), vecs[v].exp_err);
      check($sformatf("v%0d_sb_empty", v), exp_q.size(), 0);
      tick();
      check($sformatf("v%0d_idle", v), int'(busy_o), 0);
    end

    // drain with downstream stalls
    xfers = 0;
    pat = '{1, 0, 0, 1, 1, 0, 1};
    sq = {3, 1, 4, 1};
    drive_frame(4, sq);
    for (int i = 0; i < 7; i++) begin
      wrap_rdy_i = pat[i][0];
      prev = wrap_o;
      tick();
      if (pat[i] == 0) begin
        check("stall_vld", int'(wrap_vld_o), 1);
        check("stall_hold", int'(wrap_o), int'(prev));
      end
    end
    check("stall_done", int'(done_o), 1);
    check("stall_xfers", xfers, 4);
    wrap_rdy_i = 1'b1;
    tick();

    // overrun during drain is dropped and flagged until the next frame
    xfers = 0;
    sq = {11, 12};
    drive_frame(2, sq);
    out_en_i   = 6'd7;
    wrap_rdy_i = 1'b0;
    tick();
    out_en_i   = '0;
    check("ovr_err", int'(err_o), 1);
    check("ovr_hold", int'(wrap_o), 11);
    wrap_rdy_i = 1'b1;
    wait_done(16, seen);
    check("ovr_done", int'(seen), 1);
    check("ovr_xfers", xfers, 2);
    tick();
    check("ovr_err_sticky", int'(err_o), 1);
    sq = {9};
    drive_frame(1, sq);
    check("ovr_err_clear", int'(err_o), 0);
    wait_done(16, seen);
    check("one_done", int'(seen), 1);
    tick();

    // zero-length request is rejected in IDLE
    sq = {5};
    drive_frame(0, sq);
    check("zero_busy", int'(busy_o), 0);
    check("zero_err", int'(err_o), 1);
    check("zero_vld", int'(wrap_vld_o), 0);

    // asynchronous reset abandons a partly captured frame
    sq = {1, 2};
    drive_frame(5, sq);
    #2 rst_i = 1'b0;
    #1;
    check("mid_rst_wrap", int'(wrap_o), 0);
    check("mid_rst_vld", int'(wrap_vld_o), 0);
    check("mid_rst_busy", int'(busy_o), 0);
    check("mid_rst_done", int'(done_o), 0);
    check("mid_rst_err", int'(err_o), 0);
    exp_q.delete();
    #2 rst_i = 1'b1;
    xfers = 0;
    sq = {17, 18};
    drive_frame(2, sq);
    wait_done(16, seen);
    check("post_rst_done", int'(seen), 1);
    check("post_rst_xfers", xfers, 2);
    check("post_rst_sb_empty", exp_q.size(), 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
